// File: rtl/alu_reservation_station.sv
// alu_reservation_station: buffers ALU/branch/address ops until operands
// are ready, snoops the ALU and LSB result buses, issues one op per cycle.
//
// Ports
//   clk, rst_in (sync, active high), rdy_in (global stall), clear (flush)
//   disp_*        dispatch request and operand/tag fields
//   rs_full       no free entry (combinational from the busy vector)
//   alu_cdb_*     ALU result broadcast
//   lsb_cdb_*     load/store buffer result broadcast
//   execute       registered one-cycle issue pulse
//   op_type       issued op type ("type" itself is a reserved keyword)
//   val1, val2    issued operands
//   entry, nowPC  issued ROB tag and PC
module alu_reservation_station #(
  parameter int RS_SIZE      = 8,
  parameter int OP_WIDTH     = 7,
  parameter int VAL_WIDTH    = 32,
  parameter int ROB_ID_WIDTH = 4,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    clear,
  input  logic                    disp_valid,
  input  logic [OP_WIDTH-1:0]     disp_type,
  input  logic [VAL_WIDTH-1:0]    disp_val1,
  input  logic                    disp_dep1,
  input  logic [ROB_ID_WIDTH:0]   disp_tag1,
  input  logic [VAL_WIDTH-1:0]    disp_val2,
  input  logic                    disp_dep2,
  input  logic [ROB_ID_WIDTH:0]   disp_tag2,
  input  logic [ROB_ID_WIDTH:0]   disp_entry,
  input  logic [ADDR_WIDTH-1:0]   disp_pc,
  output logic                    rs_full,
  input  logic                    alu_cdb_valid,
  input  logic [ROB_ID_WIDTH:0]   alu_cdb_entry,
  input  logic [VAL_WIDTH-1:0]    alu_cdb_val,
  input  logic                    lsb_cdb_valid,
  input  logic [ROB_ID_WIDTH:0]   lsb_cdb_entry,
  input  logic [VAL_WIDTH-1:0]    lsb_cdb_val,
  output logic                    execute,
  output logic [OP_WIDTH-1:0]     op_type,
  output logic [VAL_WIDTH-1:0]    val1,
  output logic [VAL_WIDTH-1:0]    val2,
  output logic [ROB_ID_WIDTH:0]   entry,
  output logic [ADDR_WIDTH-1:0]   nowPC
);

  localparam int IW = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0]    r_busy;
  logic [RS_SIZE-1:0]    r_q1;
  logic [RS_SIZE-1:0]    r_q2;
  logic [OP_WIDTH-1:0]   r_type  [RS_SIZE];
  logic [ROB_ID_WIDTH:0] r_tag1  [RS_SIZE];
  logic [ROB_ID_WIDTH:0] r_tag2  [RS_SIZE];
  logic [VAL_WIDTH-1:0]  r_v1    [RS_SIZE];
  logic [VAL_WIDTH-1:0]  r_v2    [RS_SIZE];
  logic [ROB_ID_WIDTH:0] r_entry [RS_SIZE];
  logic [ADDR_WIDTH-1:0] r_pc    [RS_SIZE];

  logic [RS_SIZE-1:0]    w_ready;
  logic                  w_iss_ok;
  logic [IW-1:0]         w_iss_idx;
  logic [IW-1:0]         w_free_idx;
  logic                  w_d_q1;
  logic                  w_d_q2;
  logic [VAL_WIDTH-1:0]  w_d_v1;
  logic [VAL_WIDTH-1:0]  w_d_v2;
  logic                  w_disp;

  assign w_ready = r_busy & ~r_q1 & ~r_q2;
  assign rs_full = &r_busy;
  assign w_disp  = disp_valid & ~rs_full;

  // Downward scans leave the lowest matching index in the result.
  always_comb begin
    w_iss_ok   = 1'b0;
    w_iss_idx  = '0;
    w_free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (w_ready[i]) begin
        w_iss_ok  = 1'b1;
        w_iss_idx = IW'(i);
      end
      if (!r_busy[i]) begin
        w_free_idx = IW'(i);
      end
    end
  end

  // Capture an operand broadcast in the dispatch cycle itself.
  always_comb begin
    w_d_q1 = disp_dep1;
    w_d_v1 = disp_val1;
    if (disp_dep1 && alu_cdb_valid &&
        alu_cdb_entry == disp_tag1) begin
      w_d_q1 = 1'b0;
      w_d_v1 = alu_cdb_val;
    end else if (disp_dep1 && lsb_cdb_valid &&
                 lsb_cdb_entry == disp_tag1) begin
      w_d_q1 = 1'b0;
      w_d_v1 = lsb_cdb_val;
    end
    w_d_q2 = disp_dep2;
    w_d_v2 = disp_val2;
    if (disp_dep2 && alu_cdb_valid &&
        alu_cdb_entry == disp_tag2) begin
      w_d_q2 = 1'b0;
      w_d_v2 = alu_cdb_val;
    end else if (disp_dep2 && lsb_cdb_valid &&
                 lsb_cdb_entry == disp_tag2) begin
      w_d_q2 = 1'b0;
      w_d_v2 = lsb_cdb_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_busy  <= '0;
      execute <= 1'b0;
      op_type <= '0;
      val1    <= '0;
      val2    <= '0;
      entry   <= '0;
      nowPC   <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        r_busy  <= '0;
        execute <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (r_busy[i] && r_q1[i]) begin
            if (alu_cdb_valid && alu_cdb_entry == r_tag1[i]) begin
              r_q1[i] <= 1'b0;
              r_v1[i] <= alu_cdb_val;
            end else if (lsb_cdb_valid &&
                         lsb_cdb_entry == r_tag1[i]) begin
              r_q1[i] <= 1'b0;
              r_v1[i] <= lsb_cdb_val;
            end
          end
          if (r_busy[i] && r_q2[i]) begin
            if (alu_cdb_valid && alu_cdb_entry == r_tag2[i]) begin
              r_q2[i] <= 1'b0;
              r_v2[i] <= alu_cdb_val;
            end else if (lsb_cdb_valid &&
                         lsb_cdb_entry == r_tag2[i]) begin
              r_q2[i] <= 1'b0;
              r_v2[i] <= lsb_cdb_val;
            end
          end
        end
        // Dispatch writes a free slot; issue frees a busy one.
        if (w_disp) begin
          r_busy[w_free_idx]  <= 1'b1;
          r_type[w_free_idx]  <= disp_type;
          r_q1[w_free_idx]    <= w_d_q1;
          r_q2[w_free_idx]    <= w_d_q2;
          r_tag1[w_free_idx]  <= disp_tag1;
          r_tag2[w_free_idx]  <= disp_tag2;
          r_v1[w_free_idx]    <= w_d_v1;
          r_v2[w_free_idx]    <= w_d_v2;
          r_entry[w_free_idx] <= disp_entry;
          r_pc[w_free_idx]    <= disp_pc;
        end
        if (w_iss_ok) begin
          execute           <= 1'b1;
          op_type           <= r_type[w_iss_idx];
          val1              <= r_v1[w_iss_idx];
          val2              <= r_v2[w_iss_idx];
          entry             <= r_entry[w_iss_idx];
          nowPC             <= r_pc[w_iss_idx];
          r_busy[w_iss_idx] <= 1'b0;
        end else begin
          execute <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// tb_alu_reservation_station: directed scenarios plus random traffic
// checked cycle by cycle against a slot-list reference model.
module tb_alu_reservation_station;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, clear;
  logic        disp_valid, disp_dep1, disp_dep2;
  logic [6:0]  disp_type;
  logic [31:0] disp_val1, disp_val2, disp_pc;
  logic [4:0]  disp_tag1, disp_tag2, disp_entry;
  logic        rs_full;
  logic        alu_cdb_valid, lsb_cdb_valid;
  logic [4:0]  alu_cdb_entry, lsb_cdb_entry;
  logic [31:0] alu_cdb_val, lsb_cdb_val;
  logic        execute;
  logic [6:0]  op_type;
  logic [31:0] val1, val2, nowPC;
  logic [4:0]  entry;

  int n_vec = 0;
  int n_err = 0;

  alu_reservation_station dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .disp_valid(disp_valid), .disp_type(disp_type),
    .disp_val1(disp_val1), .disp_dep1(disp_dep1),
    .disp_tag1(disp_tag1), .disp_val2(disp_val2),
    .disp_dep2(disp_dep2), .disp_tag2(disp_tag2),
    .disp_entry(disp_entry), .disp_pc(disp_pc),
    .rs_full(rs_full),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_entry(alu_cdb_entry),
    .alu_cdb_val(alu_cdb_val),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_entry(lsb_cdb_entry),
    .lsb_cdb_val(lsb_cdb_val),
    .execute(execute), .op_type(op_type), .val1(val1),
    .val2(val2), .entry(entry), .nowPC(nowPC)
  );

  always #5 clk = ~clk;

  // Reference model: eight slots, each holding one waiting op.
  bit          m_busy [8];
  bit          m_q1   [8];
  bit          m_q2   [8];
  logic [4:0]  m_t1   [8];
  logic [4:0]  m_t2   [8];
  logic [31:0] m_v1   [8];
  logic [31:0] m_v2   [8];
  logic [6:0]  m_ty   [8];
  logic [4:0]  m_en   [8];
  logic [31:0] m_pc   [8];
  bit          e_exec;
  logic [6:0]  e_ty;
  logic [31:0] e_v1, e_v2, e_pc;
  logic [4:0]  e_en;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_full();
    bit f = 1'b1;
    for (int i = 0; i < 8; i++) if (!m_busy[i]) f = 1'b0;
    return f;
  endfunction

  // Operand lookup on both result buses; ALU bus wins.
  function automatic void snoop(input bit dep, input logic [4:0] tag,
                                input logic [31:0] v, output bit q,
                                output logic [31:0] o);
    q = dep;
    o = v;
    if (dep && alu_cdb_valid && alu_cdb_entry == tag) begin
      q = 1'b0;
      o = alu_cdb_val;
    end else if (dep && lsb_cdb_valid && lsb_cdb_entry == tag) begin
      q = 1'b0;
      o = lsb_cdb_val;
    end
  endfunction

  task automatic model_edge();
    int iss = -1;
    int fr = -1;
    bit full;
    bit q;
    logic [31:0] v;
    if (rst_in) begin
      for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
      e_exec = 0; e_ty = '0; e_v1 = '0; e_v2 = '0;
      e_en = '0; e_pc = '0;
    end else if (!rdy_in) begin
      // frozen
    end else if (clear) begin
      for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
      e_exec = 0;
    end else begin
      full = m_full();
      for (int i = 0; i < 8; i++) begin
        if (iss < 0 && m_busy[i] && !m_q1[i] && !m_q2[i]) iss = i;
        if (fr < 0 && !m_busy[i]) fr = i;
      end
      e_exec = (iss >= 0);
      if (iss >= 0) begin
        e_ty = m_ty[iss]; e_v1 = m_v1[iss]; e_v2 = m_v2[iss];
        e_en = m_en[iss]; e_pc = m_pc[iss];
      end
      for (int i = 0; i < 8; i++) begin
        if (m_busy[i] && m_q1[i]) begin
          snoop(1'b1, m_t1[i], m_v1[i], q, v);
          m_q1[i] = q; m_v1[i] = v;
        end
        if (m_busy[i] && m_q2[i]) begin
          snoop(1'b1, m_t2[i], m_v2[i], q, v);
          m_q2[i] = q; m_v2[i] = v;
        end
      end
      if (disp_valid && !full) begin
        m_busy[fr] = 1'b1;
        m_ty[fr] = disp_type; m_en[fr] = disp_entry;
        m_pc[fr] = disp_pc;
        m_t1[fr] = disp_tag1; m_t2[fr] = disp_tag2;
        snoop(disp_dep1, disp_tag1, disp_val1, q, v);
        m_q1[fr] = q; m_v1[fr] = v;
        snoop(disp_dep2, disp_tag2, disp_val2, q, v);
        m_q2[fr] = q; m_v2[fr] = v;
      end
      if (iss >= 0) m_busy[iss] = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("execute", execute, e_exec);
    chk("rs_full", rs_full, m_full());
    chk("type", op_type, e_ty);
    chk("val1", val1, e_v1);
    chk("val2", val2, e_v2);
    chk("entry", entry, e_en);
    chk("nowPC", nowPC, e_pc);
  endtask

  task automatic idle();
    disp_valid = 0; alu_cdb_valid = 0; lsb_cdb_valid = 0;
    clear = 0;
  endtask

  task automatic disp(input logic [6:0] ty, input logic [31:0] v1,
                      input logic d1, input logic [4:0] t1,
                      input logic [31:0] v2, input logic d2,
                      input logic [4:0] t2, input logic [4:0] en,
                      input logic [31:0] pc);
    disp_valid = 1; disp_type = ty;
    disp_val1 = v1; disp_dep1 = d1; disp_tag1 = t1;
    disp_val2 = v2; disp_dep2 = d2; disp_tag2 = t2;
    disp_entry = en; disp_pc = pc;
  endtask

  initial begin
    rst_in = 1; rdy_in = 1; clear = 0;
    disp_valid = 0; disp_type = '0; disp_dep1 = 0; disp_dep2 = 0;
    disp_val1 = '0; disp_val2 = '0; disp_tag1 = '0; disp_tag2 = '0;
    disp_entry = '0; disp_pc = '0;
    alu_cdb_valid = 0; alu_cdb_entry = '0; alu_cdb_val = '0;
    lsb_cdb_valid = 0; lsb_cdb_entry = '0; lsb_cdb_val = '0;
    step(); step();
    chk("rst_exec", execute, 0);
    chk("rst_full", rs_full, 0);
    rst_in = 0;

    // ready op issues two edges after dispatch
    disp(7'h13, 5, 0, 0, 7, 0, 0, 3, 32'h100);
    step(); idle();
    chk("t1_early", execute, 0);
    step();
    chk("t1_exec", execute, 1);
    chk("t1_val1", val1, 5);
    chk("t1_val2", val2, 7);
    chk("t1_entry", entry, 3);
    step();
    chk("t1_once", execute, 0);

    // operand 1 woken by the ALU bus
    disp(7'h33, 0, 1, 6, 2, 0, 0, 4, 32'h104);
    step(); idle();
    step(); chk("t2_wait", execute, 0);
    alu_cdb_valid = 1; alu_cdb_entry = 6; alu_cdb_val = 32'h100;
    step(); idle(); chk("t2_wake", execute, 0);
    step();
    chk("t2_exec", execute, 1);
    chk("t2_val1", val1, 32'h100);

    // operand 2 captured at dispatch from the LSB bus
    disp(7'h63, 1, 0, 0, 0, 1, 9, 5, 32'h108);
    lsb_cdb_valid = 1; lsb_cdb_entry = 9; lsb_cdb_val = 32'hFFFF_FFFF;
    step(); idle();
    step();
    chk("t3_exec", execute, 1);
    chk("t3_val2", val2, 32'hFFFF_FFFF);
    step();

    // fill all slots, overflow is dropped, drain in order
    for (int i = 0; i < 8; i++) begin
      disp(7'h13, i, 1, 1, 0, 0, 0, 5'(i), 32'h200 + 4 * i);
      step();
    end
    chk("t4_full", rs_full, 1);
    disp(7'h13, 0, 1, 1, 0, 0, 0, 20, 32'h300);
    step(); idle();
    chk("t4_full2", rs_full, 1);
    alu_cdb_valid = 1; alu_cdb_entry = 1; alu_cdb_val = 32'h55;
    step(); idle();
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t4_exec", execute, 1);
      chk("t4_order", entry, 5'(i));
      if (i == 0) chk("t4_fulldrop", rs_full, 0);
    end
    step();
    chk("t4_no_ovf", execute, 0);

    // flush discards everything, including same-cycle dispatch
    for (int i = 0; i < 4; i++) begin
      disp(7'h13, 0, 1, 2, 0, 0, 0, 5'(10 + i), 32'h400);
      step();
    end
    disp(7'h13, 1, 0, 0, 1, 0, 0, 15, 32'h500);
    clear = 1;
    step(); idle();
    chk("t5_exec", execute, 0);
    chk("t5_full", rs_full, 0);
    alu_cdb_valid = 1; alu_cdb_entry = 2; alu_cdb_val = 32'h77;
    step(); idle();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_dead", execute, 0);
    end

    // stall holds a ready entry until rdy_in returns
    disp(7'h13, 1, 0, 0, 2, 0, 0, 5, 32'h600);
    step(); idle();
    rdy_in = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_stall", execute, 0);
    end
    rdy_in = 1;
    step();
    chk("t6_exec", execute, 1);
    chk("t6_entry", entry, 5);
    step();
    chk("t6_once", execute, 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rst_in = ($urandom_range(0, 499) == 0);
      rdy_in = ($urandom_range(0, 7) != 0);
      clear = ($urandom_range(0, 63) == 0);
      disp_valid = !m_full() && ($urandom_range(0, 2) != 0);
      disp_type = 7'($urandom);
      disp_val1 = $urandom; disp_val2 = $urandom;
      disp_dep1 = $urandom_range(0, 1) == 1;
      disp_dep2 = $urandom_range(0, 1) == 1;
      disp_tag1 = 5'($urandom_range(0, 7));
      disp_tag2 = 5'($urandom_range(0, 7));
      disp_entry = 5'($urandom); disp_pc = $urandom;
      alu_cdb_valid = ($urandom_range(0, 2) == 0);
      alu_cdb_entry = 5'($urandom_range(0, 7));
      alu_cdb_val = $urandom;
      lsb_cdb_valid = ($urandom_range(0, 2) == 0);
      lsb_cdb_entry = 5'($urandom_range(0, 7));
      lsb_cdb_val = $urandom;
      if (alu_cdb_valid && lsb_cdb_entry == alu_cdb_entry)
        lsb_cdb_valid = 0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Reservation station feeding the integer ALU in the out-of-order core.
- Buffers dispatched ALU/branch/address ops until both operands are valid.
- Snoops the two result broadcast buses (ALU and load/store buffer) to capture operands.
- Issues at most one ready op per cycle to the ALU as a registered one-cycle execute pulse.

Parameters:
RS_SIZE, 8, number of entries; power of two, minimum 2
OP_WIDTH, 7, width of the op type code passed to the ALU
VAL_WIDTH, 32, operand/result width
ROB_ID_WIDTH, 4, ROB index width; all tags are ROB_ID_WIDTH+1 bits
ADDR_WIDTH, 32, PC width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global enable; when low, all state holds
clear  in  1  misprediction flush
disp_valid  in  1  dispatch request
disp_type  in  OP_WIDTH  op type code
disp_val1  in  VAL_WIDTH  operand 1 value (meaningful if disp_dep1=0)
disp_dep1  in  1  operand 1 waits on a tag
disp_tag1  in  ROB_ID_WIDTH+1  producer tag for operand 1
disp_val2  in  VAL_WIDTH  operand 2 value
disp_dep2  in  1  operand 2 waits on a tag
disp_tag2  in  ROB_ID_WIDTH+1  producer tag for operand 2
disp_entry  in  ROB_ID_WIDTH+1  destination ROB tag
disp_pc  in  ADDR_WIDTH  instruction PC
rs_full  out  1  no free entry (combinational from busy vector)
alu_cdb_valid  in  1  ALU result broadcast valid
alu_cdb_entry  in  ROB_ID_WIDTH+1  ALU result tag
alu_cdb_val  in  VAL_WIDTH  ALU result value
lsb_cdb_valid  in  1  load/store buffer result valid
lsb_cdb_entry  in  ROB_ID_WIDTH+1  LSB result tag
lsb_cdb_val  in  VAL_WIDTH  LSB result value
execute  out  1  one-cycle issue pulse to ALU
type  out  OP_WIDTH  issued op type
val1  out  VAL_WIDTH  issued operand 1
val2  out  VAL_WIDTH  issued operand 2
entry  out  ROB_ID_WIDTH+1  issued ROB tag
nowPC  out  ADDR_WIDTH  issued PC

Behaviour:
- Reset (rst_in=1 at edge):
  - All busy bits 0.
  - execute, type, val1, val2, entry and nowPC all 0.
  - rs_full=0.
- Priority at each edge: rst_in > !rdy_in (hold everything, outputs included) > clear > normal operation.
- Clear:
  - All busy bits 0; execute <= 0.
  - Same-cycle dispatch is discarded.
  - Data outputs may hold their previous values.
- Per-entry state: busy, type, q1/q2 (waiting flags), tag1/tag2, v1/v2, entry, pc.
- Dispatch:
  - Accepted when disp_valid=1 and rs_full=0.
  - Written into the lowest-index non-busy entry.
  - If disp_valid=1 while rs_full=1, the request is ignored; the dispatcher must not do this.
- Dispatch forwarding:
  - If a waiting operand's tag equals a valid CDB tag in the same cycle, the operand is stored as ready, taking the CDB value.
  - The ALU CDB is checked before the LSB CDB; both buses never carry the same tag.
- Wakeup:
  - Every busy entry with qN=1 and tagN matching a valid CDB tag sets qN=0 and vN to the CDB value at that edge.
  - Operand 1 and operand 2 are handled independently.
- Issue select:
  - Combinational over the pre-edge state: the lowest-index entry with busy=1, q1=0 and q2=0.
  - An entry woken at edge N is issuable at the earliest in the cycle after edge N, so it issues at edge N+1.
- Issue:
  - If a candidate exists, execute <= 1 and type/val1/val2/entry/nowPC are loaded from it; the entry's busy <= 0 at the same edge.
  - Otherwise execute <= 0 and the data outputs hold.
  - Latency: an entry dispatched with both operands ready at edge N pulses execute in the cycle after edge N+1.
- rs_full:
  - Equals AND of all busy bits.
  - A slot freed by issue at an edge is usable for dispatch in the following cycle, not the same one.
- Simultaneous dispatch, wakeup and issue in one cycle are all legal and independent (they target different entries).
- The stall hold is safe: the ALU is also frozen while rdy_in=0, so a held execute pulse is consumed exactly once.

Test Plan:
- Reset, then dispatch type=addi, val1=5, val2=7, entry=3, no deps -> execute=1 for exactly one cycle, two edges after dispatch, with val1=5, val2=7, entry=3; rs_full=0 throughout.
- Dispatch with dep1 on tag 6, then alu_cdb_valid with entry=6, val=0x100 two cycles later -> no issue before the wakeup; execute pulses one edge after the wakeup with val1=0x100.
- Dispatch with dep2 on tag 9 in the same cycle as lsb_cdb_valid, entry=9, val=0xFFFF_FFFF -> operand captured at dispatch; issues with val2=0xFFFF_FFFF.
- Fill 8 entries all waiting on tag 1 -> rs_full=1, and a ninth dispatch is dropped; broadcast tag 1 -> entries issue in index order 0..7 on consecutive cycles; rs_full drops the cycle after the first issue.
- Fill 4 entries, assert clear together with a dispatch -> all busy bits 0 and execute=0 next cycle; nothing issues afterwards, even when the awaited tags are broadcast.
- An entry is ready, then rdy_in is held low for 3 cycles -> no state change and execute is not re-pulsed; the issue completes on the first edge with rdy_in=1.
